// File: rtl/pmem_ram_boot_pkg.sv
// Shared types and constants for the loadable RV32 instruction memory.
package pmem_ram_boot_pkg;

  // addi x0, x0, 0: the canonical RV32 no-op presented to the core when no real word is available
  localparam logic [31:0] PMEM_NOP_WORD = 32'h0000_0013;

  // Boot-load sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  // Number of words addressed by a byte address of width addr_w
  function automatic int pmem_depth(input int addr_w);
    return 32'sd1 << (addr_w - 32'sd2);
  endfunction

  // Width of a word index for a byte address of width addr_w
  function automatic int pmem_idx_w(input int addr_w);
    return addr_w - 32'sd2;
  endfunction

endpackage

// File: rtl/pmem_ram_boot_load_fsm.sv
// Boot-load sequencer: validates a load request, then streams words into
// consecutive memory indices through a valid/ready handshake.
module pmem_ram_boot_load_fsm
  import pmem_ram_boot_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic [pmem_idx_w(ADDR_W)-1:0] load_base,
  input  logic [ADDR_W-2:0]             load_len,
  input  logic                          load_vld,
  input  logic [DATA_W-1:0]             load_data,
  output logic                          load_rdy,
  output logic                          load_busy,
  output logic                          load_done,
  output logic                          load_err,
  output logic                          busy_nxt,
  output logic                          wr_en,
  output logic [pmem_idx_w(ADDR_W)-1:0] wr_idx,
  output logic [DATA_W-1:0]             wr_data
);

  localparam int IDX_W = pmem_idx_w(ADDR_W);
  localparam int LEN_W = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(pmem_depth(ADDR_W));

  load_state_t       state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] req_end_s;

  // One past the last index the request would touch; the sum cannot overflow ADDR_W bits
  assign req_end_s = {2'b00, load_base} + {1'b0, load_len};

  // Next-state, counter and write-strobe logic of the load sequencer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (req_end_s > DEPTH_V) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (load_len == LEN_W'(0)) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            ptr_d   = load_base;
            cnt_d   = load_len;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (load_vld) begin
          wr_en = 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            // ptr is left on the last written index so it never steps past DEPTH-1
            state_d = DONE;
            cnt_d   = LEN_W'(0);
          end else begin
            state_d = LOAD;
            ptr_d   = ptr_q + IDX_W'(1);
            cnt_d   = cnt_q - LEN_W'(1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs are decoded from the next state so they register in step with it
    rdy_d  = (state_d == LOAD);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Sequencer state, counters and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(0);
      cnt_q   <= LEN_W'(0);
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign load_rdy  = rdy_q;
  assign load_busy = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign busy_nxt  = busy_d;
  assign wr_idx    = ptr_q;
  assign wr_data   = load_data;

endmodule

// File: rtl/pmem_ram_boot.sv
// Loadable instruction memory: word-addressed RAM with a stall-able fetch
// pipeline of 1 or 2 cycles and a streamed boot-load port.
module pmem_ram_boot
  import pmem_ram_boot_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(PMEM_NOP_WORD)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             pc_read_c0,
  input  logic                          fetch_stall,
  output logic [DATA_W-1:0]             instr_reg,
  output logic                          instr_vld,
  input  logic                          load_start,
  input  logic [pmem_idx_w(ADDR_W)-1:0] load_base,
  input  logic [ADDR_W-2:0]             load_len,
  input  logic                          load_vld,
  input  logic [DATA_W-1:0]             load_data,
  output logic                          load_rdy,
  output logic                          load_busy,
  output logic                          load_done,
  output logic                          load_err
);

  localparam int DEPTH = pmem_depth(ADDR_W);
  localparam int IDX_W = pmem_idx_w(ADDR_W);

  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
    $error("pmem_ram_boot: RD_LAT must be 1 or 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              busy_nxt_s;
  logic [IDX_W-1:0]  fetch_idx_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] pipe_word_s;
  logic              pipe_vld_s;
  logic              pc_unused_s;
  logic [DATA_W-1:0] instr_reg_q, instr_reg_d;
  logic              instr_vld_q, instr_vld_d;

  pmem_ram_boot_load_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_load_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_vld   (load_vld),
    .load_data  (load_data),
    .load_rdy   (load_rdy),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .busy_nxt   (busy_nxt_s),
    .wr_en      (wr_en_s),
    .wr_idx     (wr_idx_s),
    .wr_data    (wr_data_s)
  );

  // Instructions are word aligned; the byte offset carries no information
  assign pc_unused_s = ^pc_read_c0[1:0];
  assign fetch_idx_s = pc_read_c0[ADDR_W-1:2];
  assign rd_word_s   = mem_q[fetch_idx_s];

  // Memory array write port; contents are deliberately not reset so an image survives rst_n
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= wr_data_s;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] stage_q, stage_d;
    logic              stage_vld_q, stage_vld_d;

    // Intermediate fetch stage: flushed while a load is active, frozen on stall
    always_comb begin
      if (busy_nxt_s) begin
        stage_d     = NOP_WORD;
        stage_vld_d = 1'b0;
      end else if (fetch_stall) begin
        stage_d     = stage_q;
        stage_vld_d = stage_vld_q;
      end else begin
        stage_d     = rd_word_s;
        stage_vld_d = 1'b1;
      end
    end

    // Intermediate fetch stage registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q     <= NOP_WORD;
        stage_vld_q <= 1'b0;
      end else begin
        stage_q     <= stage_d;
        stage_vld_q <= stage_vld_d;
      end
    end

    assign pipe_word_s = stage_q;
    assign pipe_vld_s  = stage_vld_q;
  end else begin : g_lat1
    assign pipe_word_s = rd_word_s;
    assign pipe_vld_s  = 1'b1;
  end

  // Output stage: NOP while loading or invalid, held on stall, otherwise the fetched word
  always_comb begin
    if (busy_nxt_s) begin
      // Decoded from the next busy value so the NOP appears in the same cycle load_busy rises
      instr_reg_d = NOP_WORD;
      instr_vld_d = 1'b0;
    end else if (fetch_stall) begin
      instr_reg_d = instr_reg_q;
      instr_vld_d = instr_vld_q;
    end else if (pipe_vld_s) begin
      instr_reg_d = pipe_word_s;
      instr_vld_d = 1'b1;
    end else begin
      instr_reg_d = NOP_WORD;
      instr_vld_d = 1'b0;
    end
  end

  // Output stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg_q <= NOP_WORD;
      instr_vld_q <= 1'b0;
    end else begin
      instr_reg_q <= instr_reg_d;
      instr_vld_q <= instr_vld_d;
    end
  end

  assign instr_reg = instr_reg_q;
  assign instr_vld = instr_vld_q;

endmodule

// File: tb/tb_pmem_ram_boot.sv
// Bench for pmem_ram_boot: two instances (RD_LAT=1 and RD_LAT=2) share all inputs
// and are compared against a word-array plus sampled-pc-queue reference model.
module tb_pmem_ram_boot;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] pc_read_c0 = '0;
  logic              fetch_stall = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W-3:0] load_base = '0;
  logic [ADDR_W-2:0] load_len = '0;
  logic              load_vld = 1'b0;
  logic [DATA_W-1:0] load_data = '0;

  logic [DATA_W-1:0] instr_reg1, instr_reg2;
  logic              instr_vld1, instr_vld2;
  logic              load_rdy1, load_busy1, load_done1, load_err1;
  logic              load_rdy2, load_busy2, load_done2, load_err2;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];
  int          pq[$];

  always #5 clk = ~clk;

  pmem_ram_boot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pc_read_c0(pc_read_c0), .fetch_stall(fetch_stall),
    .instr_reg(instr_reg1), .instr_vld(instr_vld1),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_vld(load_vld), .load_data(load_data),
    .load_rdy(load_rdy1), .load_busy(load_busy1), .load_done(load_done1), .load_err(load_err1)
  );

  pmem_ram_boot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pc_read_c0(pc_read_c0), .fetch_stall(fetch_stall),
    .instr_reg(instr_reg2), .instr_vld(instr_vld2),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_vld(load_vld), .load_data(load_data),
    .load_rdy(load_rdy2), .load_busy(load_busy2), .load_done(load_done2), .load_err(load_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_ld(input string tag, input logic rdy, input logic busy,
                        input logic done, input logic err);
    chk({tag, "/rdy1"},  {31'b0, load_rdy1},  {31'b0, rdy});
    chk({tag, "/busy1"}, {31'b0, load_busy1}, {31'b0, busy});
    chk({tag, "/done1"}, {31'b0, load_done1}, {31'b0, done});
    chk({tag, "/err1"},  {31'b0, load_err1},  {31'b0, err});
    chk({tag, "/rdy2"},  {31'b0, load_rdy2},  {31'b0, rdy});
    chk({tag, "/busy2"}, {31'b0, load_busy2}, {31'b0, busy});
    chk({tag, "/done2"}, {31'b0, load_done2}, {31'b0, done});
    chk({tag, "/err2"},  {31'b0, load_err2},  {31'b0, err});
  endtask

  // Output at latency L is the word at the pc sampled L non-stalled edges ago
  task automatic check_fetch(input string tag);
    for (int l = 1; l <= 2; l++) begin
      logic [31:0] got_w;
      logic        got_v;
      logic        exp_v;
      int          idx;
      got_w = (l == 1) ? instr_reg1 : instr_reg2;
      got_v = (l == 1) ? instr_vld1 : instr_vld2;
      exp_v = (pq.size() >= l);
      chk($sformatf("%s/vld_lat%0d", tag, l), {31'b0, got_v}, {31'b0, exp_v});
      if (!exp_v) begin
        chk($sformatf("%s/nop_lat%0d", tag, l), got_w, NOP);
      end else begin
        idx = pq[pq.size() - l];
        if (known[idx]) chk($sformatf("%s/word_lat%0d", tag, l), got_w, ref_mem[idx]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && !fetch_stall) begin
      pq.push_back(int'(pc_read_c0[ADDR_W-1:2]));
      if (pq.size() > 4) void'(pq.pop_front());
    end
    #1;
  endtask

  task automatic fetch_pc(input string tag, input int widx, input bit stall);
    pc_read_c0  = ADDR_W'(widx * 4 + $urandom_range(3));
    fetch_stall = stall;
    tick();
    check_fetch(tag);
  endtask

  // pat/pat_n give an explicit load_vld sequence; after it, vld is random at vld_pct.
  // abort_after>0 pulls rst_n after that many accepted words.
  task automatic do_load(input string tag, input int base, input int len, input int vld_pct,
                         input bit [7:0] pat, input int pat_n, input bit inject,
                         input int abort_after);
    int  ptr;
    int  accepted;
    int  cycles;
    bit  v;
    fetch_stall = 1'b0;
    load_start  = 1'b1;
    load_base   = (ADDR_W-2)'(base);
    load_len    = (ADDR_W-1)'(len);
    load_vld    = 1'b0;
    tick();
    load_start  = 1'b0;
    if (base + len > DEPTH) begin
      chk_ld({tag, "/err"}, 1'b0, 1'b0, 1'b0, 1'b1);
      check_fetch({tag, "/err_fetch"});
      tick();
      chk_ld({tag, "/err_end"}, 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    ptr = base;
    accepted = 0;
    cycles = 0;
    while (accepted < len) begin
      chk_ld($sformatf("%s/acc%0d", tag, accepted), 1'b1, 1'b1, 1'b0, 1'b0);
      chk({tag, "/busy_nop1"}, instr_reg1, NOP);
      chk({tag, "/busy_nop2"}, instr_reg2, NOP);
      chk({tag, "/busy_vld"}, {30'b0, instr_vld1, instr_vld2}, 32'd0);
      if (cycles < pat_n) v = pat[cycles];
      else v = ($urandom_range(99) < vld_pct) || (cycles >= 4 * len);
      load_vld  = v;
      load_data = $urandom;
      if (inject && cycles == 1) begin
        load_start = 1'b1;
        load_base  = '0;
        load_len   = 9'd1;
      end
      tick();
      load_start = 1'b0;
      if (v) begin
        ref_mem[ptr] = load_data;
        known[ptr]   = 1'b1;
        ptr++;
        accepted++;
      end
      cycles++;
      if (abort_after > 0 && accepted == abort_after) begin
        rst_n    = 1'b0;
        load_vld = 1'b0;
        #1;
        pq.delete();
        chk_ld({tag, "/abort"}, 1'b0, 1'b0, 1'b0, 1'b0);
        check_fetch({tag, "/abort"});
        tick();
        chk_ld({tag, "/abort_hold"}, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        return;
      end
    end
    load_vld = 1'b0;
    chk_ld({tag, "/done"}, 1'b0, 1'b1, 1'b1, 1'b0);
    chk({tag, "/done_nop1"}, instr_reg1, NOP);
    chk({tag, "/done_vld"}, {30'b0, instr_vld1, instr_vld2}, 32'd0);
    pq.delete();
    tick();
    chk_ld({tag, "/idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int len;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // 1. reset values and pipeline fill after release
    rst_n = 1'b0;
    tick();
    tick();
    chk_ld("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_fetch("reset");
    rst_n = 1'b1;
    check_fetch("rel0");
    tick();
    check_fetch("rel1");
    tick();
    check_fetch("rel2");

    // 2. load 4 words at base 0 with vld every cycle, then fetch them back
    do_load("load4", 0, 4, 100, 8'h00, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) fetch_pc("fetch4", i, 1'b0);
    fetch_pc("fetch4_drain", 3, 1'b0);
    fetch_pc("fetch4_drain", 0, 1'b0);

    // 3. boundary: exact fit at top of memory, then overrun rejected, then empty load
    do_load("top_fit", DEPTH - 2, 2, 100, 8'h00, 0, 1'b0, 0);
    do_load("top_err", DEPTH - 2, 3, 100, 8'h00, 0, 1'b0, 0);
    do_load("over_err", 1, DEPTH, 100, 8'h00, 0, 1'b0, 0);
    do_load("len0", 5, 0, 100, 8'h00, 0, 1'b0, 0);
    fetch_pc("top_chk", DEPTH - 2, 1'b0);
    fetch_pc("top_chk", DEPTH - 1, 1'b0);
    fetch_pc("top_chk", 2, 1'b0);

    // 4. vld gaps 1,0,0,1,1 with a stray load_start mid-load
    do_load("gaps", 32, 3, 0, 8'b0001_1001, 5, 1'b1, 0);
    for (int i = 32; i < 35; i++) fetch_pc("gaps_chk", i, 1'b0);
    fetch_pc("gaps_chk", 0, 1'b0);
    fetch_pc("gaps_chk", 1, 1'b0);

    // 5. stall for 3 cycles while pc moves, then release
    fetch_pc("pre_stall", 1, 1'b0);
    fetch_pc("pre_stall", 1, 1'b0);
    fetch_pc("stall", 2, 1'b1);
    fetch_pc("stall", 3, 1'b1);
    fetch_pc("stall", 32, 1'b1);
    fetch_pc("post_stall", 33, 1'b0);
    fetch_pc("post_stall", 34, 1'b0);
    fetch_pc("post_stall", 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      fetch_pc("rnd_stall", $urandom_range(3), ($urandom_range(3) == 0));
    end

    // 6. reset in the middle of a 4-word load: first two words new, last two old
    do_load("old16", 16, 4, 100, 8'h00, 0, 1'b0, 0);
    do_load("abort16", 16, 4, 100, 8'h00, 0, 1'b0, 2);
    check_fetch("after_abort");
    for (int i = 16; i < 20; i++) fetch_pc("abort_chk", i, 1'b0);
    fetch_pc("abort_chk", 19, 1'b0);
    fetch_pc("abort_chk", 16, 1'b0);

    // randomized loads (some out of range) interleaved with randomized fetch/stall traffic
    for (int r = 0; r < 12; r++) begin
      base = $urandom_range(DEPTH - 1);
      len  = $urandom_range(8);
      do_load($sformatf("rnd_load%0d", r), base, len, 60, 8'h00, 0, 1'b0, 0);
      for (int i = 0; i < 25; i++) begin
        fetch_pc("rnd_fetch", $urandom_range(DEPTH - 1), ($urandom_range(4) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
